// File: rtl/q4_lsu_if.sv
// Data-memory request/response channel between the load/store unit and memory.
// The master side issues requests; the slave side accepts them and returns responses.
interface q4_lsu_if;
    logic        dmem_req_valid_op;
    logic        dmem_req_ready_ip;
    logic        dmem_req_we_op;
    logic [31:0] dmem_req_addr_op;
    logic [3:0]  dmem_req_wstrb_op;
    logic [31:0] dmem_req_wdata_op;
    logic        dmem_rsp_valid_ip;
    logic [31:0] dmem_rsp_rdata_ip;

    modport master (
        output dmem_req_valid_op,
        output dmem_req_we_op,
        output dmem_req_addr_op,
        output dmem_req_wstrb_op,
        output dmem_req_wdata_op,
        input  dmem_req_ready_ip,
        input  dmem_rsp_valid_ip,
        input  dmem_rsp_rdata_ip
    );

    modport slave (
        input  dmem_req_valid_op,
        input  dmem_req_we_op,
        input  dmem_req_addr_op,
        input  dmem_req_wstrb_op,
        input  dmem_req_wdata_op,
        output dmem_req_ready_ip,
        output dmem_rsp_valid_ip,
        output dmem_rsp_rdata_ip
    );
endinterface

// File: rtl/q4_lsu.sv
// Memory-stage load/store unit: issues one aligned data-memory access per instruction,
// formats load results and stalls the pipeline until the access completes.
module q4_lsu #(
    parameter int CTRL_WIDTH      = 16,
    parameter int CTRL_MEM_RD_BIT = 0,
    parameter int CTRL_MEM_WR_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           alu_out_ip,
    input  logic [31:0]           reg_rd_data2_ip,
    input  logic [CTRL_WIDTH-1:0] ctrl_q4_ip,
    input  logic [31:0]           instr_ip,
    output logic                  stall_op,
    output logic [31:0]           load_data_op,
    output logic                  load_valid_op,
    output logic                  fault_op,
    q4_lsu_if.master              dmem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        mem_op;
    logic        is_store;
    logic        access_ok;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic        cap_load;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_offset;
    logic [31:0] rsp_shifted;
    logic [31:0] load_fmt;
    logic        unused_ok;

    assign unused_ok = ^{instr_ip[31:15], instr_ip[11:0], ctrl_q4_ip};

    // A store wins when both control bits are set; unsigned forms are load-only.
    always_comb begin
        mem_op      = ctrl_q4_ip[CTRL_MEM_RD_BIT] | ctrl_q4_ip[CTRL_MEM_WR_BIT];
        is_store    = ctrl_q4_ip[CTRL_MEM_WR_BIT];
        funct3      = instr_ip[14:12];
        offset      = alu_out_ip[1:0];
        access_ok   = 1'b0;
        store_wstrb = 4'b0000;
        store_wdata = reg_rd_data2_ip;
        case (funct3)
            3'b000: begin
                access_ok   = 1'b1;
                store_wstrb = 4'b0001 << offset;
                store_wdata = {4{reg_rd_data2_ip[7:0]}};
            end
            3'b001: begin
                access_ok   = ~offset[0];
                store_wstrb = 4'b0011 << offset;
                store_wdata = {2{reg_rd_data2_ip[15:0]}};
            end
            3'b010: begin
                access_ok   = (offset == 2'b00);
                store_wstrb = 4'b1111;
            end
            3'b100:  access_ok = ~is_store;
            3'b101:  access_ok = ~is_store & ~offset[0];
            default: access_ok = 1'b0;
        endcase
    end

    always_comb begin
        rsp_shifted = dmem.dmem_rsp_rdata_ip >> {cap_offset, 3'b000};
        case (cap_funct3)
            3'b000:  load_fmt = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  load_fmt = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100:  load_fmt = {24'h000000, rsp_shifted[7:0]};
            3'b101:  load_fmt = {16'h0000, rsp_shifted[15:0]};
            default: load_fmt = rsp_shifted;
        endcase
    end

    // Dropping stall in DONE lets the pipeline advance exactly once per access.
    assign stall_op = mem_op & (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            load_data_op           <= 32'h0;
            load_valid_op          <= 1'b0;
            fault_op               <= 1'b0;
            cap_load               <= 1'b0;
            cap_funct3             <= 3'b000;
            cap_offset             <= 2'b00;
            dmem.dmem_req_valid_op <= 1'b0;
            dmem.dmem_req_we_op    <= 1'b0;
            dmem.dmem_req_addr_op  <= 32'h0;
            dmem.dmem_req_wstrb_op <= 4'b0000;
            dmem.dmem_req_wdata_op <= 32'h0;
        end else begin
            load_valid_op <= 1'b0;
            fault_op      <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && access_ok) begin
                        cap_load               <= ~is_store;
                        cap_funct3             <= funct3;
                        cap_offset             <= offset;
                        dmem.dmem_req_valid_op <= 1'b1;
                        dmem.dmem_req_we_op    <= is_store;
                        dmem.dmem_req_addr_op  <= {alu_out_ip[31:2], 2'b00};
                        dmem.dmem_req_wstrb_op <= is_store ? store_wstrb : 4'b0000;
                        dmem.dmem_req_wdata_op <= store_wdata;
                        state                  <= REQ;
                    end else if (mem_op) begin
                        fault_op <= 1'b1;
                        state    <= DONE;
                    end
                end
                REQ: begin
                    if (dmem.dmem_req_ready_ip) begin
                        dmem.dmem_req_valid_op <= 1'b0;
                        state                  <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rsp_valid_ip) begin
                        if (cap_load) begin
                            load_data_op  <= load_fmt;
                            load_valid_op <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q4_lsu.sv
// Self-checking bench for q4_lsu: directed vector table, reset-abandon sequence and
// randomized accesses checked against a byte-level memory-access model.
module tb_q4_lsu;
    localparam int CTRL_WIDTH = 16;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        logic        exp_fault;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ldata;
        int          exp_stall;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           alu_out;
    logic [31:0]           rs2_data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [31:0]           instr;
    logic                  stall;
    logic [31:0]           load_data;
    logic                  load_valid;
    logic                  fault;
    int                    vec_count = 0;
    int                    miss_count = 0;
    logic [31:0]           last_load;
    vec_t                  table_v [12];

    q4_lsu_if dmem ();

    q4_lsu #(
        .CTRL_WIDTH      (CTRL_WIDTH),
        .CTRL_MEM_RD_BIT (0),
        .CTRL_MEM_WR_BIT (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_out_ip      (alu_out),
        .reg_rd_data2_ip (rs2_data),
        .ctrl_q4_ip      (ctrl),
        .instr_ip        (instr),
        .stall_op        (stall),
        .load_data_op    (load_data),
        .load_valid_op   (load_valid),
        .fault_op        (fault),
        .dmem            (dmem)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        ctrl           = '0;
        ctrl[0]        = rd;
        ctrl[1]        = wr;
        instr          = 32'h0;
        instr[14:12]   = f3;
        instr[6:0]     = wr ? 7'b0100011 : 7'b0000011;
        alu_out        = addr;
        rs2_data       = data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/stall"},      32'(stall), 32'd0);
        checkOutput({tag, "/load_data"},  load_data, 32'd0);
        checkOutput({tag, "/load_valid"}, 32'(load_valid), 32'd0);
        checkOutput({tag, "/fault"},      32'(fault), 32'd0);
        checkOutput({tag, "/req_valid"},  32'(dmem.dmem_req_valid_op), 32'd0);
        checkOutput({tag, "/req_we"},     32'(dmem.dmem_req_we_op), 32'd0);
        checkOutput({tag, "/req_addr"},   dmem.dmem_req_addr_op, 32'd0);
        checkOutput({tag, "/req_wstrb"},  32'(dmem.dmem_req_wstrb_op), 32'd0);
        checkOutput({tag, "/req_wdata"},  dmem.dmem_req_wdata_op, 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        dmem.dmem_req_ready_ip = 1'b0;
        dmem.dmem_rsp_valid_ip = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        last_load = 32'h0;
        @(negedge clk);
    endtask

    // Access described in terms of bytes touched, not of the unit's lane logic.
    function automatic vec_t modelAccess(input logic rd, input logic wr, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] data,
                                         input logic [31:0] rdata, input int rdy_dly,
                                         input int rsp_dly, input logic [31:0] prev_load);
        vec_t        v;
        int          size = 0;
        bit          uns = 0;
        bit          flt;
        int          off;
        logic [31:0] raw;
        logic [31:0] mask;
        off = int'(addr % 4);
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; end
            3'd5: begin size = 2; uns = 1; end
            default: size = 0;
        endcase
        if (size == 0) flt = 1;
        else flt = (wr && uns) || ((addr % size) != 0);
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = data; v.rdata = rdata;
        v.rdy_dly   = rdy_dly;
        v.rsp_dly   = rsp_dly;
        v.exp_fault = flt;
        v.exp_addr  = addr & ~32'h3;
        v.exp_we    = wr;
        v.exp_strb  = 4'h0;
        v.exp_wdata = 32'h0;
        v.exp_ldata = prev_load;
        v.exp_stall = flt ? 1 : 3 + rdy_dly + rsp_dly;
        if (!flt && wr) begin
            for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = data[8*(i % size) +: 8];
            for (int i = 0; i < size; i++) v.exp_strb[off + i] = 1'b1;
        end
        if (!flt && !wr) begin
            raw  = rdata >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
            raw  = raw & mask;
            if (!uns && size < 4 && raw[8*size-1]) raw = raw | ~mask;
            v.exp_ldata = raw;
        end
        return v;
    endfunction

    // Runs one access starting just after a negedge, acting as the memory.
    task automatic runAccess(input vec_t v, input string tag);
        int stall_cnt = 0;
        int req_cnt   = 0;
        int wait_cnt  = 0;
        bit accepted  = 0;
        bit done      = 0;
        bit saw_req   = 0;
        applyStimulus(v.rd, v.wr, v.f3, v.addr, v.rs2);
        dmem.dmem_rsp_rdata_ip = v.rdata;
        for (int c = 0; c < 80 && !done; c++) begin
            dmem.dmem_req_ready_ip = dmem.dmem_req_valid_op ? (req_cnt >= v.rdy_dly) : (v.rdy_dly == 0);
            dmem.dmem_rsp_valid_ip = accepted && (wait_cnt >= v.rsp_dly);
            #1;
            if (!stall) begin
                done = 1;
                checkOutput({tag, "/fault"},      32'(fault), 32'(v.exp_fault));
                checkOutput({tag, "/load_valid"}, 32'(load_valid), 32'(v.rd & ~v.wr & ~v.exp_fault));
                checkOutput({tag, "/load_data"},  load_data, v.exp_ldata);
            end else begin
                stall_cnt++;
                if (dmem.dmem_req_valid_op) begin
                    saw_req = 1;
                    req_cnt++;
                    checkOutput({tag, "/req_addr"},  dmem.dmem_req_addr_op, v.exp_addr);
                    checkOutput({tag, "/req_we"},    32'(dmem.dmem_req_we_op), 32'(v.exp_we));
                    checkOutput({tag, "/req_wstrb"}, 32'(dmem.dmem_req_wstrb_op), 32'(v.exp_strb));
                    if (v.wr) checkOutput({tag, "/req_wdata"}, dmem.dmem_req_wdata_op, v.exp_wdata);
                end
                if (accepted) wait_cnt++;
                if (dmem.dmem_req_valid_op && dmem.dmem_req_ready_ip) accepted = 1;
            end
            @(negedge clk);
        end
        checkOutput({tag, "/completed"},    32'(done), 32'd1);
        checkOutput({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        checkOutput({tag, "/req_issued"},   32'(saw_req), 32'(!v.exp_fault));
        dmem.dmem_req_ready_ip = 1'b0;
        dmem.dmem_rsp_valid_ip = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checkOutput({tag, "/idle_stall"},      32'(stall), 32'd0);
        checkOutput({tag, "/idle_fault"},      32'(fault), 32'd0);
        checkOutput({tag, "/idle_load_valid"}, 32'(load_valid), 32'd0);
        checkOutput({tag, "/idle_req_valid"},  32'(dmem.dmem_req_valid_op), 32'd0);
        @(negedge clk);
        if (!done) doReset();
        else last_load = v.exp_ldata;
    endtask

    initial begin
        vec_t v;
        // rd wr f3 addr rs2 rdata rdy rsp | fault addr we strb wdata ldata stall
        table_v[0]  = '{1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h100, 0, 4'h0, 32'h0,        32'hDEADBEEF, 3};
        table_v[1]  = '{1, 0, 3'd0, 32'h203, 32'h0,        32'h80112233, 0, 0, 0, 32'h200, 0, 4'h0, 32'h0,        32'hFFFFFF80, 3};
        table_v[2]  = '{1, 0, 3'd4, 32'h203, 32'h0,        32'h80112233, 0, 0, 0, 32'h200, 0, 4'h0, 32'h0,        32'h00000080, 3};
        table_v[3]  = '{1, 0, 3'd5, 32'h202, 32'h0,        32'h80112233, 1, 2, 0, 32'h200, 0, 4'h0, 32'h0,        32'h00008011, 6};
        table_v[4]  = '{0, 1, 3'd1, 32'h032, 32'h1234ABCD, 32'h0,        0, 0, 0, 32'h030, 1, 4'hC, 32'hABCDABCD, 32'h00008011, 3};
        table_v[5]  = '{1, 0, 3'd2, 32'h102, 32'h0,        32'h0,        0, 0, 1, 32'h0,   0, 4'h0, 32'h0,        32'h00008011, 1};
        table_v[6]  = '{0, 1, 3'd4, 32'h040, 32'h55,       32'h0,        0, 0, 1, 32'h0,   0, 4'h0, 32'h0,        32'h00008011, 1};
        table_v[7]  = '{0, 1, 3'd2, 32'h080, 32'hCAFEF00D, 32'h0,        5, 0, 0, 32'h080, 1, 4'hF, 32'hCAFEF00D, 32'h00008011, 8};
        table_v[8]  = '{1, 0, 3'd1, 32'h206, 32'h0,        32'h7FFF0000, 0, 7, 0, 32'h204, 0, 4'h0, 32'h0,        32'h00007FFF, 10};
        table_v[9]  = '{1, 1, 3'd0, 32'h011, 32'h000000A5, 32'h0,        0, 0, 0, 32'h010, 1, 4'h2, 32'hA5A5A5A5, 32'h00007FFF, 3};
        table_v[10] = '{1, 0, 3'd3, 32'h000, 32'h0,        32'h0,        0, 0, 1, 32'h0,   0, 4'h0, 32'h0,        32'h00007FFF, 1};
        table_v[11] = '{1, 0, 3'd1, 32'h201, 32'h0,        32'h0,        0, 0, 1, 32'h0,   0, 4'h0, 32'h0,        32'h00007FFF, 1};

        rst = 1'b1;
        last_load = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        dmem.dmem_req_ready_ip = 1'b0;
        dmem.dmem_rsp_valid_ip = 1'b0;
        dmem.dmem_rsp_rdata_ip = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) runAccess(table_v[i], $sformatf("vec%0d", i));

        // Abandon a load in WAIT via reset; its late response must be ignored.
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h300, 32'h0);
        dmem.dmem_req_ready_ip = 1'b1;
        dmem.dmem_rsp_valid_ip = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abandon/req_valid", 32'(dmem.dmem_req_valid_op), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("abandon/wait_req_valid", 32'(dmem.dmem_req_valid_op), 32'd0);
        checkOutput("abandon/wait_stall",     32'(stall), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        dmem.dmem_req_ready_ip = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAllZero("abandon/after_reset");
        @(negedge clk);
        dmem.dmem_rsp_valid_ip = 1'b1;
        dmem.dmem_rsp_rdata_ip = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkAllZero($sformatf("abandon/stale_rsp%0d", i));
            @(negedge clk);
        end
        dmem.dmem_rsp_valid_ip = 1'b0;
        last_load = 32'h0;
        v = modelAccess(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h13579BDF, 0, 0, last_load);
        runAccess(v, "abandon/next_lw");

        for (int i = 0; i < 40; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(1, 3));
            v = modelAccess(kind[0], kind[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
                            $urandom, $urandom_range(0, 3), $urandom_range(0, 3), last_load);
            runAccess(v, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/q4_lsu.md
Name: q4_lsu

Overview:
- Memory-access-stage load/store unit. It consumes the execute-to-memory pipeline register outputs: ALU address, store data, control word and instruction.
- Drives a valid/ready data-memory request channel and a response channel.
- Formats load data with byte/halfword alignment and sign or zero extension.
- Holds the pipeline with a stall while a memory transaction is in flight.

Parameters:
- CTRL_WIDTH, 16, width of the pipeline control word.
- CTRL_MEM_RD_BIT, 0, bit index in the control word meaning load.
- CTRL_MEM_WR_BIT, 1, bit index in the control word meaning store.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_out_ip  in  32  effective byte address.
- reg_rd_data2_ip  in  32  store data (rs2).
- ctrl_q4_ip  in  CTRL_WIDTH  control word for the memory stage.
- instr_ip  in  32  instruction; funct3 = [14:12].
- stall_op  out  1  hold upstream registers this cycle.
- load_data_op  out  32  formatted load result.
- load_valid_op  out  1  load_data_op valid this cycle.
- fault_op  out  1  misaligned or illegal-size access, one-cycle pulse.
- dmem_req_valid_op  out  1  request valid.
- dmem_req_ready_ip  in  1  memory accepts request.
- dmem_req_we_op  out  1  1 = write.
- dmem_req_addr_op  out  32  word address; bits [1:0] = 0.
- dmem_req_wstrb_op  out  4  byte write strobes.
- dmem_req_wdata_op  out  32  lane-replicated write data.
- dmem_rsp_valid_ip  in  1  response/ack valid.
- dmem_rsp_rdata_ip  in  32  read word.

Behaviour:
- mem_op = ctrl[CTRL_MEM_RD_BIT] | ctrl[CTRL_MEM_WR_BIT]. If both bits are set, treat the access as a store.
- FSM states are IDLE, REQ, WAIT and DONE. The state is registered.
- IDLE:
  - With mem_op and a legal, aligned access, capture the request fields into registers and go to REQ.
  - With mem_op and an illegal or misaligned access, go to DONE with fault latched. No request is issued.
  - Otherwise stay in IDLE.
- REQ: dmem_req_valid_op = 1. Addr, we, wstrb and wdata are stable while valid. Go to WAIT on the cycle dmem_req_ready_ip = 1.
- WAIT:
  - dmem_req_valid_op = 0.
  - On dmem_rsp_valid_ip, go to DONE.
  - For loads, latch the formatted dmem_rsp_rdata_ip.
  - Waiting is unbounded.
- DONE: for one cycle, load_valid_op = 1 for a successful load and fault_op = 1 for a faulted access. Then return to IDLE.
- stall_op = mem_op & (state != DONE), combinational. It is low in DONE so the pipeline advances exactly once.
- Legal funct3 values and alignment rules:
  - 000 LB/SB: any address.
  - 001 LH/SH: address[0] = 0.
  - 010 LW/SW: address[1:0] = 0.
  - 100 LBU and 101 LHU: loads only, same alignment as the signed forms.
  - Any other funct3, or 100/101 on a store, is illegal and sets fault.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << a[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << a[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- Loads issue with wstrb = 0000.
- Load formatting:
  - Shift rdata right by a[1:0]*8.
  - Sign-extend from bit 7 or 15 for LB/LH; zero-extend for LBU/LHU.
- load_data_op holds its last value until the next load completes.
- dmem_rsp_valid_ip in IDLE or REQ is ignored, covering stale responses after a reset mid-transaction.
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including load_data_op and stall_op. stall_op may go high in the first cycle after reset if mem_op is present.
  - An outstanding request is abandoned.
- Minimum latency for an accepted access with ready already high and the response arriving one cycle after acceptance:
  - stall_op is high for 3 cycles (IDLE, REQ, WAIT).
  - DONE occurs in cycle 4.

Test Plan:
- LW at 0x100, ready = 1, rsp next cycle with 0xDEADBEEF -> addr 0x100, we = 0, wstrb 0000; stall high 3 cycles; DONE: load_data_op = 0xDEADBEEF, load_valid_op = 1.
- LB at 0x203 with rdata 0x80112233 -> load_data_op = 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x202 -> 0x00008011.
- SH at 0x32 with rs2 = 0x1234ABCD -> addr 0x30, we = 1, wstrb 1100, wdata 0xABCDABCD. DONE after the ack; load_valid_op = 0.
- LW at 0x102 -> no dmem_req_valid_op ever; stall high 1 cycle; fault_op pulses in DONE. Store with funct3 = 100 -> same fault behaviour.
- Back-pressure: ready low for 5 cycles, then high -> req fields stable throughout, stall held. Response delayed 7 cycles -> remains in WAIT, then completes normally.
- Assert rst while in WAIT; a response arrives 2 cycles later -> response ignored; all outputs 0; the next LW completes correctly.
